dm_sba_axi_lite: RTL

AXI4-Lite master bridge directly downstream of the debug module's system-bus-access (SBA) host port. It converts the req/gnt/r_valid host handshake into single-beat AXI4-Lite reads and writes toward the SoC interconnect. Exactly one transaction is outstanding at a time, and every access, read or write, completes with exactly one r_valid_o pulse.

---
 rtl/dm_sba_axi_pkg.sv | 24 ++
 rtl/dm_sba_axi_lite.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dm_sba_axi_pkg.sv
// Shared types and constants for the SBA-to-AXI4-Lite bridge.
package dm_sba_axi_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } sba_state_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   // Privileged, secure, data access.
   localparam logic [2:0] SbaProt = 3'b001;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RespOkay;
   endfunction

endpackage

// File: rtl/dm_sba_axi_lite.sv
// SBA host port to single-outstanding AXI4-Lite master; optional error capture under DM_SBA_AXI_ERR_EN.
// Latency: grant to r_valid_o is 3 cycles minimum, one access per 4 cycles back to back.
// Backpressure: every AXI wait state stalls 1:1 with no timeout; no grant until back in IDLE.
module dm_sba_axi_lite
   import dm_sba_axi_pkg::*;
#(
   parameter int BusWidth  = 32,
   parameter int AddrWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [BusWidth-1:0]   add_i,
   input  logic                  we_i,
   input  logic [BusWidth-1:0]   wdata_i,
   input  logic [BusWidth/8-1:0] be_i,
   output logic                  gnt_o,
   output logic                  r_valid_o,
   output logic [BusWidth-1:0]   r_rdata_o,
   output logic [AddrWidth-1:0]  aw_addr_o,
   output logic [2:0]            aw_prot_o,
   output logic                  aw_valid_o,
   input  logic                  aw_ready_i,
   output logic [BusWidth-1:0]   w_data_o,
   output logic [BusWidth/8-1:0] w_strb_o,
   output logic                  w_valid_o,
   input  logic                  w_ready_i,
   input  logic [1:0]            b_resp_i,
   input  logic                  b_valid_i,
   output logic                  b_ready_o,
   output logic [AddrWidth-1:0]  ar_addr_o,
   output logic [2:0]            ar_prot_o,
   output logic                  ar_valid_o,
   input  logic                  ar_ready_i,
   input  logic [BusWidth-1:0]   r_data_i,
   input  logic [1:0]            r_resp_i,
   input  logic                  r_valid_i,
   output logic                  r_ready_o
`ifdef DM_SBA_AXI_ERR_EN
   ,
   output logic                  err_o,
   output logic [AddrWidth-1:0]  err_addr_o,
   input  logic                  err_clr_i
`endif
);

   sba_state_e                state_q, state_d;
   logic [AddrWidth-1:0]      addr_q;
   logic [BusWidth-1:0]       wdata_q;
   logic [BusWidth/8-1:0]     be_q;
   logic [BusWidth-1:0]       rdata_q;
   logic                      aw_done_q;
   logic                      w_done_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  addr_q    <= AddrWidth'(add_i);
                  wdata_q   <= wdata_i;
                  be_q      <= be_i;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
               end
            end
            WR_REQ: begin
               if (aw_valid_o && aw_ready_i) aw_done_q <= 1'b1;
               if (w_valid_o && w_ready_i)   w_done_q  <= 1'b1;
            end
            WR_RESP: begin
               if (b_valid_i) rdata_q <= '0;
            end
            RD_RESP: begin
               // Data is returned regardless of the response code.
               if (r_valid_i) rdata_q <= r_data_i;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_o      = 1'b0;
      aw_valid_o = 1'b0;
      w_valid_o  = 1'b0;
      b_ready_o  = 1'b0;
      ar_valid_o = 1'b0;
      r_ready_o  = 1'b0;
      r_valid_o  = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_o = req_i;
            if (req_i) state_d = we_i ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            aw_valid_o = !aw_done_q;
            w_valid_o  = !w_done_q;
            if ((aw_done_q || aw_ready_i) && (w_done_q || w_ready_i))
               state_d = WR_RESP;
         end
         WR_RESP: begin
            b_ready_o = 1'b1;
            if (b_valid_i) state_d = DONE;
         end
         RD_REQ: begin
            ar_valid_o = 1'b1;
            if (ar_ready_i) state_d = RD_RESP;
         end
         RD_RESP: begin
            r_ready_o = 1'b1;
            if (r_valid_i) state_d = DONE;
         end
         DONE: begin
            r_valid_o = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign aw_addr_o = addr_q;
   assign ar_addr_o = addr_q;
   assign aw_prot_o = SbaProt;
   assign ar_prot_o = SbaProt;
   assign w_data_o  = wdata_q;
   assign w_strb_o  = be_q;
   assign r_rdata_o = rdata_q;

`ifdef DM_SBA_AXI_ERR_EN
   logic                 resp_err;
   logic                 err_q;
   logic [AddrWidth-1:0] err_addr_q;

   assign resp_err = ((state_q == WR_RESP) && b_valid_i && resp_is_err(b_resp_i)) ||
                     ((state_q == RD_RESP) && r_valid_i && resp_is_err(r_resp_i));

   // A new error takes priority over a simultaneous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else if (resp_err) begin
         err_q      <= 1'b1;
         err_addr_q <= addr_q;
      end else if (err_clr_i) begin
         err_q      <= 1'b0;
      end
   end

   assign err_o      = err_q;
   assign err_addr_o = err_addr_q;
`else
   logic unused_resp;
   assign unused_resp = ^{b_resp_i, r_resp_i};
`endif

endmodule
